spram_arbiter: RTL
==================

# spram_arbiter

Sequences and shares the single 16-bit SP256K frame store between two requesters. The SPI-side writer stores incoming light words. The LED-driver-side reader fetches words for output. The block clears the memory after reset, then arbitrates word-level accesses round-robin. It owns all SPRAM address, data and write-enable pins.

## Interface
Parameters:
- AW, 14, SPRAM address width
- DW, 16, data width
- CLEAR_ON_RESET, 1, zero-fill memory after reset (0 = skip, go straight to IDLE)
- CLEAR_WORDS, 16384, number of words zero-filled (addresses 0..CLEAR_WORDS-1)

Ports:
- clk  in  1  FPGA clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request; level, held until wr_ack
- wr_addr  in  AW  write address, stable while wr_req
- wr_data  in  DW  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse: write being performed this cycle
- rd_req  in  1  read request; level, held until rd_ack
- rd_addr  in  AW  read address, stable while rd_req
- rd_ack  out  1  one-cycle pulse: read address presented to SPRAM this cycle
- rd_data  out  DW  read word, registered
- rd_valid  out  1  one-cycle pulse: rd_data valid
- busy  out  1  high while clearing; requests ignored
- ram_addr  out  AW  to SPRAM AD
- ram_di  out  DW  to SPRAM DI
- ram_we  out  1  to SPRAM WE (MASKWE tied 4'b1111 at instantiation)
- ram_do  in  DW  from SPRAM DO, valid one cycle after address edge

## Operation
- FSM states: CLEAR, IDLE, WRITE, READ, RDATA. The reset state is CLEAR, or IDLE if CLEAR_ON_RESET=0.
- CLEAR:
  - ram_we=1, ram_di=0, ram_addr = clear counter, counting up by 1 per cycle.
  - After address CLEAR_WORDS-1 is driven, go to IDLE.
  - busy=1 throughout CLEAR. wr_ack and rd_ack stay 0.
- IDLE, arbitration:
  - If only one request is high, grant it.
  - If both are high, grant the one opposite to last_grant.
  - last_grant resets to READ, so the first tie goes to the writer.
  - Write grant: register ram_addr<=wr_addr, ram_di<=wr_data, ram_we<=1. Go to WRITE.
  - Read grant: register ram_addr<=rd_addr, ram_we<=0. Go to READ.
  - No request: ram_we<=0. ram_addr and ram_di hold.
- WRITE: wr_ack=1 and ram_we=1 for this cycle only. Go to IDLE; ram_we returns to 0 on exit.
- READ: rd_ack=1 for this cycle. SPRAM captures the address at the end of the cycle. Go to RDATA.
- RDATA:
  - rd_data<=ram_do and rd_valid<=1 at the end of the cycle; rd_valid is high for the next cycle only.
  - Go to IDLE. That IDLE cycle may grant a new request at the same time as rd_valid is high.
- last_grant updates on every grant.
- Requests that drop before being granted are simply not serviced. No error flag.
- Addresses are passed through unmodified. No bounds check; AW covers the whole SPRAM.

## Timing
- Reset values: wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0, ram_we=0, ram_addr=0, ram_di=0, busy=CLEAR_ON_RESET.
- Reset is asynchronous and may arrive mid-operation. It takes effect immediately:
  - ram_we drops at once, so an in-flight write is abandoned.
  - A pending rd_valid is lost.
  - The clear restarts from address 0 after release.
- Clear timing:
  - ram_we is high for exactly CLEAR_WORDS consecutive cycles, starting the cycle after the first rising edge following reset_n release.
  - busy falls in the cycle after the last clear write.
  - The first request can be sampled on the edge where busy is low.
- Write, request sampled at edge E0:
  - WRITE cycle (wr_ack=1, ram_we=1) is E0..E1; memory is written at E1.
  - Throughput is 1 write per 2 cycles.
- Read, request sampled at E0:
  - rd_ack in E0..E1.
  - ram_do valid in E1..E2.
  - rd_valid/rd_data in E2..E3.
  - Latency is 3 edges; throughput is 1 read per 3 cycles.
- Simultaneous requests alternate, so neither side waits more than one other access.
- Worst-case wait before a grant is 3 cycles.

## Test plan
- CLEAR_WORDS=8, reset release -> ram_we high for 8 cycles with addresses 0..7 and ram_di=0, then busy=0. wr_req held during clear is not acked until after busy falls.
- Write wr_addr=0x0005, wr_data=0xA5C3, then read rd_addr=0x0005 -> wr_ack single pulse, rd_ack, then rd_valid with rd_data=0xA5C3 exactly 3 edges after the read was sampled.
- wr_req and rd_req asserted together and held for 4 grants -> grant order W,R,W,R. Each ack is a single pulse. No cycle has ram_we=1 during READ/RDATA.
- Back-to-back reads at addresses 1,2,3, preloaded 0x1111/0x2222/0x3333 -> three rd_valid pulses spaced 3 cycles apart, with data in order.
- reset_n asserted during a WRITE cycle -> ram_we=0 and wr_ack=0 immediately. After release, the clear restarts at address 0 and the old write is not retried.
- CLEAR_ON_RESET=0 -> busy=0 from reset. A write at the first edge after release is acked in the next cycle.

Source files
------------

// File: rtl/spram_arbiter.sv
// spram_arbiter
//   Shares one single-port SPRAM frame store between two requesters. The SPI
//   writer stores light words. The LED-driver reader fetches them. After reset
//   the block zero-fills the memory. It then grants word accesses round-robin.
//
// Ports
//   clk, reset_n          clock (rising edge); asynchronous active-low reset
//   wr_req/wr_addr/wr_data write request with its address and data
//   wr_ack                pulse: the write is being performed this cycle
//   rd_req/rd_addr        read request with its address
//   rd_ack                pulse: the read address is on the SPRAM this cycle
//   rd_data/rd_valid      registered read word and its one-cycle strobe
//   busy                  high while the memory is being cleared
//   ram_addr/ram_di/ram_we/ram_do  SPRAM pins (ram_do is registered in the SPRAM)
//   dbg_state             current FSM state, for observation only
//
// Handshake: each req is a level. The requester holds req, addr and data
// stable until it sees its ack pulse for one cycle. It must drop or change
// req on the clock edge that ends the ack cycle. A request that drops before
// it is acked is not serviced. While busy is high, requests are ignored.
module spram_arbiter #(
  parameter int AW             = 14,
  parameter int DW             = 16,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CLEAR_WORDS    = 16384
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  output logic          ram_we,
  input  logic [DW-1:0] ram_do,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  // One extra bit so the counter can reach CLEAR_WORDS, which may equal 2**AW.
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] CLR_END = CW'(CLEAR_WORDS);

  localparam logic G_WR = 1'b0;
  localparam logic G_RD = 1'b1;

  state_t        state, state_next;
  logic [CW-1:0] clr_cnt;
  logic          clr_done;
  logic          last_grant;
  logic          grant_wr, grant_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    clr_done   = (clr_cnt == CLR_END);
    case (state)
      S_CLEAR: if (clr_done) state_next = S_IDLE;
      S_IDLE: begin
        // On a tie, the side that did not win last time is served.
        if (wr_req && (!rd_req || last_grant == G_RD)) begin
          grant_wr   = 1'b1;
          state_next = S_WRITE;
        end else if (rd_req) begin
          grant_rd   = 1'b1;
          state_next = S_READ;
        end
      end
      S_WRITE: state_next = S_IDLE;
      S_READ:  state_next = S_RDATA;
      S_RDATA: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_ack    = (state == S_WRITE);
  assign rd_ack    = (state == S_READ);
  assign busy      = (state == S_CLEAR);
  assign dbg_state = state;

  // The SPRAM pins are registered. A grant taken in IDLE puts address, data and
  // write enable on the pins for the following WRITE/READ cycle. clr_cnt counts
  // the words already issued. The exit edge is therefore the edge after the last
  // clear write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr   <= '0;
      ram_di     <= '0;
      ram_we     <= 1'b0;
      clr_cnt    <= '0;
      last_grant <= G_RD;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (!clr_done) begin
            ram_we   <= 1'b1;
            ram_addr <= clr_cnt[AW-1:0];
            ram_di   <= '0;
            clr_cnt  <= clr_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (grant_wr) begin
            ram_addr <= wr_addr;
            ram_di   <= wr_data;
            ram_we   <= 1'b1;
          end else if (grant_rd) begin
            ram_addr <= rd_addr;
          end
        end
        default: ;
      endcase

      if (grant_wr)      last_grant <= G_WR;
      else if (grant_rd) last_grant <= G_RD;

      rd_valid <= (state == S_RDATA);
      if (state == S_RDATA) rd_data <= ram_do;
    end
  end

endmodule
